tea_output_collector: RTL and testbench
=======================================

TEA_OUTPUT_COLLECTOR -- requirements
Module: tea_output_collector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: FIFO depth in 64-bit blocks, a power of two.
REQ-002 The block SHALL have parameter WARMUP, default 32: number of initial ena cycles whose blocks are discarded as garbage.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port ena  input  1  decryptor-array advance strobe; one block is offered per cycle with ena=1.
REQ-006 The block SHALL have port inBlock64  input  64  decrypted block from the parallel decryptor array.
REQ-007 The block SHALL have port clr_ovf  input  1  clears the overflow flag and the drop counter.
REQ-008 The block SHALL have port out_word  output  32  serialized plaintext word.
REQ-009 The block SHALL have port out_valid  output  1  out_word holds a valid word.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts out_word.
REQ-011 The block SHALL have port rdy  output  1  warm-up complete; incoming blocks are now relevant.
REQ-012 The block SHALL have port level  output  $clog2(DEPTH)+1  number of blocks currently stored.
REQ-013 The block SHALL have port ovf  output  1  sticky flag: at least one relevant block was dropped.
REQ-014 The block SHALL have port drop_cnt  output  16  count of dropped blocks, saturating at 16'hFFFF.

Function
REQ-015 The warm-up counter SHALL increment on each rising edge with ena=1 while below WARMUP, then saturate at WARMUP.
REQ-016 rdy SHALL be 1 exactly when the warm-up counter equals WARMUP, as a registered output.
REQ-017 A block on a cycle with ena=1 and rdy=0 SHALL be discarded and SHALL NOT count as a drop.
REQ-018 A block on a cycle with ena=1 and rdy=1 SHALL be a push candidate; with ena=0 nothing is pushed.
REQ-019 A push SHALL be accepted if level<DEPTH, or if level==DEPTH and a pop completes in the same cycle.
REQ-020 A rejected push SHALL set ovf and increment drop_cnt by 1, saturating.
REQ-021 The FIFO SHALL use wrap-around read and write pointers of $clog2(DEPTH) bits, with level tracked separately.
REQ-022 The output serializer SHALL have states IDLE, HI, LO.
REQ-023 In IDLE with level>0 the serializer SHALL go to HI on the next edge; otherwise it SHALL stay in IDLE.
REQ-024 In HI, out_word SHALL be head block bits [63:32] with out_valid=1; on out_valid&&out_ready the serializer SHALL go to LO.
REQ-025 In LO, out_word SHALL be head block bits [31:0] with out_valid=1; on a transfer the head block SHALL be popped (level decrements).
REQ-026 After a pop in LO, the serializer SHALL go to HI if at least one further block remains, else to IDLE.
REQ-027 When a push and a pop occur in the same cycle, level SHALL be unchanged.
REQ-028 Output latency SHALL be 2 cycles: a push accepted at edge N gives out_valid=1 in HI after edge N+1 if the FIFO was empty and the serializer was in IDLE.
REQ-029 out_word SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 In IDLE, out_word SHALL be 0 and out_valid SHALL be 0.
REQ-031 clr_ovf=1 SHALL clear ovf and drop_cnt on the next edge.
REQ-032 If a drop and clr_ovf occur in the same cycle, the drop SHALL win: ovf=1 and drop_cnt=1.
REQ-033 ena SHALL NOT gate the output side; draining continues while ena=0.

Reset
REQ-034 With rst=0 at a rising edge, the block SHALL clear the warm-up counter, pointers and level to 0 and the serializer to IDLE.
REQ-035 With rst=0 at a rising edge, the block SHALL set rdy=0, out_valid=0, out_word=0, ovf=0, drop_cnt=0 and level=0.
REQ-036 Reset mid-transfer SHALL discard all stored blocks and restart warm-up; FIFO contents need not be cleared.

Verification
REQ-037 Warm-up test: 32 ena cycles with inBlock64=64'hDEAD_BEEF_0000_0001 -> no push, level=0; rdy=1 after edge 32; the 33rd block is pushed.
REQ-038 Ordering test: after warm-up push 64'h0123_4567_89AB_CDEF with out_ready=1 -> out_word 32'h0123_4567 then 32'h89AB_CDEF on consecutive cycles, then out_valid=0.
REQ-039 Overflow test: with out_ready=0 push 10 blocks at DEPTH=8 -> level=8, ovf=1, drop_cnt=2; after clr_ovf=1 -> ovf=0, drop_cnt=0, level=8.
REQ-040 Full simultaneous push/pop test: level=8 in LO with out_ready=1 and ena=1 -> push accepted, level stays 8, no drop.
REQ-041 Backpressure test: toggle out_ready randomly over 100 blocks -> the word stream equals the pushed blocks, high word first, with none lost or duplicated.
REQ-042 Mid-operation reset test: rst=0 for one cycle at level=5 -> next cycle level=0, out_valid=0, rdy=0, and warm-up restarts from 0.

Source files
------------

// File: rtl/tea_output_collector_if.sv
// Serialized plaintext word stream from the TEA output collector.
// The master drives word/valid; the slave returns ready.
interface tea_output_collector_if;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_word, output out_valid, input out_ready);
  modport slave  (input out_word, input out_valid, output out_ready);
endinterface

// File: rtl/tea_output_collector.sv
// Collects 64-bit TEA plaintext blocks after a warm-up period into a FIFO,
// then serializes each block as two 32-bit words (high word first).
module tea_output_collector #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WARMUP = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [63:0]             inBlock64,
  input  logic                    clr_ovf,
  tea_output_collector_if.master  dout,
  output logic                    rdy,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  output logic [15:0]             drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  state_t        state, state_nxt;
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic [63:0]   head, next_head;
  logic          pop, push, cand, drop;
  logic [31:0]   word_nxt;
  logic          valid_nxt;

  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_ptr + PW'(1)];
  assign pop       = (state == LO) && dout.out_ready;
  assign cand      = ena && rdy;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push      = cand && ((level < LW'(DEPTH)) || pop);
  assign drop      = cand && !push;
  assign wcnt_nxt  = (ena && (wcnt < WW'(WARMUP))) ? wcnt + WW'(1) : wcnt;

  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= inBlock64;
  end

  // Warm-up, FIFO bookkeeping and drop accounting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt     <= '0;
      rdy      <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wcnt <= wcnt_nxt;
      rdy  <= (wcnt_nxt == WW'(WARMUP));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      if (drop) begin
        ovf      <= 1'b1;
        drop_cnt <= clr_ovf ? 16'd1 :
                    ((drop_cnt != 16'hFFFF) ? drop_cnt + 16'd1 : drop_cnt);
      end else if (clr_ovf) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      dout.out_word  <= '0;
      dout.out_valid <= 1'b0;
    end else begin
      state          <= state_nxt;
      dout.out_word  <= word_nxt;
      dout.out_valid <= valid_nxt;
    end
  end

  // Serializer: next state plus the word it will present after the edge.
  always_comb begin
    state_nxt = state;
    word_nxt  = '0;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          state_nxt = HI;
          word_nxt  = head[63:32];
          valid_nxt = 1'b1;
        end
      end
      HI: begin
        valid_nxt = 1'b1;
        word_nxt  = head[63:32];
        if (dout.out_ready) begin
          state_nxt = LO;
          word_nxt  = head[31:0];
        end
      end
      LO: begin
        valid_nxt = 1'b1;
        word_nxt  = head[31:0];
        if (dout.out_ready) begin
          // Only blocks stored before this edge count as remaining.
          if (level > LW'(1)) begin
            state_nxt = HI;
            word_nxt  = next_head[63:32];
          end else begin
            state_nxt = IDLE;
            word_nxt  = '0;
            valid_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tea_output_collector.sv
// Randomized bench for tea_output_collector against a queue-based model
// of the warm-up, FIFO and two-word serializer behaviour.
module tb_tea_output_collector;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned WARMUP = 32;

  logic        clk = 1'b0;
  logic        rst, ena, clr_ovf;
  logic [63:0] blk;
  logic        rdy, ovf;
  logic [3:0]  level;
  logic [15:0] drop_cnt;

  tea_output_collector_if dout ();

  tea_output_collector #(.DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .inBlock64 (blk),
    .clr_ovf   (clr_ovf),
    .dout      (dout),
    .rdy       (rdy),
    .level     (level),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model state
  int          m_wcnt;
  bit          m_rdy;
  bit          m_ovf;
  int          m_drop;
  int          m_phase;          // 0 idle, 1 high word shown, 2 low word shown
  logic [63:0] m_q[$];
  bit          m_acc;
  logic [31:0] exp_words[$];
  logic [31:0] got_words[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input logic [63:0] b,
                            input bit c, input bit rd);
    bit pop, cand;
    m_acc = 1'b0;
    if (!r) begin
      m_wcnt = 0; m_rdy = 0; m_ovf = 0; m_drop = 0; m_phase = 0;
      m_q.delete();
      return;
    end
    pop  = (m_phase == 2) && rd;
    cand = e && m_rdy;
    case (m_phase)
      0: if (m_q.size() > 0) m_phase = 1;
      1: if (rd) m_phase = 2;
      default: if (rd) m_phase = (m_q.size() > 1) ? 1 : 0;
    endcase
    m_acc = cand && ((m_q.size() < DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (m_acc) begin
      m_q.push_back(b);
      exp_words.push_back(b[63:32]);
      exp_words.push_back(b[31:0]);
    end
    if (cand && !m_acc) begin
      m_ovf  = 1;
      m_drop = c ? 1 : ((m_drop < 65535) ? m_drop + 1 : 65535);
    end else if (c) begin
      m_ovf  = 0;
      m_drop = 0;
    end
    if (e && m_wcnt < WARMUP) m_wcnt++;
    m_rdy = (m_wcnt == WARMUP);
  endtask

  task automatic step(input bit r, input bit e, input logic [63:0] b,
                      input bit c, input bit rd);
    logic [31:0] w;
    rst = r; ena = e; blk = b; clr_ovf = c; dout.out_ready = rd;
    #4;
    if (r && dout.out_valid && rd) got_words.push_back(dout.out_word);
    @(posedge clk);
    #1;
    model_edge(r, e, b, c, rd);
    w = (m_phase == 0) ? 32'h0 : (m_phase == 1) ? m_q[0][63:32] : m_q[0][31:0];
    check("level",     64'(level),          64'(m_q.size()));
    check("rdy",       64'(rdy),            64'(m_rdy));
    check("ovf",       64'(ovf),            64'(m_ovf));
    check("drop_cnt",  64'(drop_cnt),       64'(m_drop));
    check("out_valid", 64'(dout.out_valid), 64'(m_phase != 0));
    check("out_word",  64'(dout.out_word),  64'(w));
  endtask

  task automatic drain(input bit rand_ready);
    for (int i = 0; i < 400 && (m_q.size() > 0 || m_phase != 0); i++)
      step(1, 0, 64'h0, 0, rand_ready ? bit'($urandom_range(0, 1)) : 1'b1);
    check("drain_level", 64'(level), 64'(0));
    check("drain_valid", 64'(dout.out_valid), 64'(0));
  endtask

  initial begin
    logic [63:0] b;
    int acc;
    rst = 0; ena = 0; blk = '0; clr_ovf = 0; dout.out_ready = 0;
    m_wcnt = 0; m_rdy = 0; m_ovf = 0; m_drop = 0; m_phase = 0;

    // reset
    step(0, 0, 64'h0, 0, 0);
    step(0, 1, 64'h1, 1, 1);
    check("rst_word", 64'(dout.out_word), 64'(0));

    // warm-up: 32 garbage blocks discarded, 33rd pushed
    for (int i = 0; i < 32; i++) begin
      if (i == 31) check("warm_rdy_low", 64'(rdy), 64'(0));
      step(1, 1, 64'hDEAD_BEEF_0000_0001, 0, 1);
      check("warm_level", 64'(level), 64'(0));
    end
    check("warm_rdy", 64'(rdy), 64'(1));
    step(1, 1, 64'h0123_4567_89AB_CDEF, 0, 1);
    check("first_push", 64'(level), 64'(1));
    step(1, 0, 64'h0, 0, 1);
    check("ord_hi", 64'(dout.out_word), 64'(32'h0123_4567));
    step(1, 0, 64'h0, 0, 1);
    check("ord_lo", 64'(dout.out_word), 64'(32'h89AB_CDEF));
    step(1, 0, 64'h0, 0, 1);
    check("ord_end", 64'(dout.out_valid), 64'(0));
    drain(0);

    // overflow: 10 pushes into 8 slots with no drain
    for (int i = 0; i < 10; i++) begin
      b = {$urandom, $urandom};
      step(1, 1, b, 0, 0);
    end
    check("ovf_level", 64'(level), 64'(8));
    check("ovf_flag", 64'(ovf), 64'(1));
    check("ovf_drops", 64'(drop_cnt), 64'(2));
    step(1, 0, 64'h0, 1, 0);
    check("clr_ovf", 64'(ovf), 64'(0));
    check("clr_drops", 64'(drop_cnt), 64'(0));
    check("clr_level", 64'(level), 64'(8));

    // full FIFO, simultaneous push and pop in LO
    step(1, 0, 64'h0, 0, 1);
    b = {$urandom, $urandom};
    step(1, 1, b, 0, 1);
    check("full_pp_level", 64'(level), 64'(8));
    check("full_pp_drops", 64'(drop_cnt), 64'(0));
    // drop and clear on the same edge: drop wins
    step(1, 1, 64'h5, 1, 0);
    check("drop_wins_ovf", 64'(ovf), 64'(1));
    check("drop_wins_cnt", 64'(drop_cnt), 64'(1));
    drain(1);

    // random backpressure over 100 accepted blocks
    exp_words.delete();
    got_words.delete();
    acc = 0;
    for (int i = 0; i < 3000 && acc < 100; i++) begin
      b = {$urandom, $urandom};
      step(1, bit'($urandom_range(0, 1)), b, ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0));
      if (m_acc) acc++;
    end
    check("rand_accepted", 64'(acc), 64'(100));
    drain(1);
    check("stream_len", 64'(got_words.size()), 64'(exp_words.size()));
    for (int i = 0; i < got_words.size() && i < exp_words.size(); i++)
      check("stream_word", 64'(got_words[i]), 64'(exp_words[i]));

    // mid-operation reset at level 5
    for (int i = 0; i < 5; i++) step(1, 1, {$urandom, $urandom}, 0, 0);
    check("pre_rst_level", 64'(level), 64'(5));
    step(0, 1, 64'h9, 0, 0);
    check("mid_rst_level", 64'(level), 64'(0));
    check("mid_rst_valid", 64'(dout.out_valid), 64'(0));
    check("mid_rst_rdy", 64'(rdy), 64'(0));
    for (int i = 0; i < 31; i++) step(1, 1, 64'h7, 0, 1);
    check("rewarm_rdy_low", 64'(rdy), 64'(0));
    step(1, 1, 64'h7, 0, 1);
    check("rewarm_rdy", 64'(rdy), 64'(1));
    step(1, 1, 64'hCAFE_F00D_1234_5678, 0, 1);
    check("rewarm_push", 64'(level), 64'(1));
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
